// File: rtl/ltl_report_collector.sv
// Report collector for an LTL monitor cluster: timestamps non-empty report vectors into a
// first-word-fall-through FIFO and keeps sticky seen/overflow/drop statistics.
module ltl_report_collector #(
  parameter int unsigned NUM_REPORTS = 4,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TS_WIDTH    = 16,
  parameter int unsigned DROP_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [NUM_REPORTS-1:0] report_in,
  input  logic                   clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_REPORTS-1:0] out_report,
  output logic [TS_WIDTH-1:0]    out_timestamp,
  output logic [NUM_REPORTS-1:0] report_seen,
  output logic                   overflow,
  output logic [DROP_WIDTH-1:0]  drop_count
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

  logic [NUM_REPORTS-1:0] rep_mem_q [FIFO_DEPTH];
  logic [TS_WIDTH-1:0]    ts_mem_q  [FIFO_DEPTH];

  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]        count_q, count_d;
  logic [TS_WIDTH-1:0]    ts_q, ts_d;
  logic [NUM_REPORTS-1:0] seen_q, seen_d;
  logic                   overflow_q, overflow_d;
  logic [DROP_WIDTH-1:0]  drop_q, drop_d;

  logic evt, full, pop, push, drop;

  always_comb begin
    evt  = run && (report_in != '0);
    full = (count_q == FullCnt);
    // out_valid comes straight from count_q, so out_ready never reaches it combinationally.
    pop  = (count_q != '0) && out_ready;
    push = evt && (!full || pop);
    drop = evt && full && !pop;

    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    wr_ptr_d = wr_ptr_q + PtrW'(push);

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    ts_d = run ? ts_q + TS_WIDTH'(1) : ts_q;

    // clear beats a same-cycle event for every statistic.
    seen_d     = clear ? '0 : (evt ? (seen_q | report_in) : seen_q);
    overflow_d = clear ? 1'b0 : (overflow_q | drop);
    drop_d     = drop_q;
    if (clear) begin
      drop_d = '0;
    end else if (drop && (drop_q != '1)) begin
      drop_d = drop_q + DROP_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ts_q       <= '0;
      seen_q     <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ts_q       <= ts_d;
      seen_q     <= seen_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage needs no reset; the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      rep_mem_q[wr_ptr_q] <= report_in;
      ts_mem_q[wr_ptr_q]  <= ts_q;
    end
  end

  assign out_valid     = (count_q != '0);
  assign out_report    = out_valid ? rep_mem_q[rd_ptr_q] : '0;
  assign out_timestamp = out_valid ? ts_mem_q[rd_ptr_q] : '0;
  assign report_seen   = seen_q;
  assign overflow      = overflow_q;
  assign drop_count    = drop_q;

endmodule
